// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: MD sequencer states and
// operand-forwarding select codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

endpackage

// File: rtl/pipe_ctrl_md_seq.sv
// Multi-cycle mul/div sequencer: IDLE -> BUSY for DIV_CYCLES cycles -> DONE,
// leaving DONE only once the data memory is ready.
module md_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      ex_md,
    input  logic      dmem_wait,
    output logic      md_busy,
    output logic      md_done,
    output md_state_e md_state
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter runs DIV_CYCLES-1 down to 0, one BUSY cycle per value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (ex_md && !dmem_wait) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) state_d = MD_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            MD_DONE: begin
                if (!dmem_wait) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign md_busy  = (state_q == MD_BUSY);
    assign md_done  = (state_q == MD_DONE);
    assign md_state = state_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard/stall/flush controller with operand forwarding.
// Define PIPE_CTRL_FWD_EN to enable forwarding; otherwise every RAW hazard stalls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int RA_W       = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            ex_we,
    input  logic            mem_we,
    input  logic            wb_we,
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic            ex_memread,
    input  logic            ex_redirect,
    input  logic            ex_md,
    input  logic            imem_wait,
    input  logic            dmem_wait,
    output logic            pc_en,
    output logic            if_id_en,
    output logic            id_ex_en,
    output logic            ex_mem_en,
    output logic            mem_wb_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            ex_mem_flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            md_busy,
    output logic            md_done,
    output md_state_e       md_state
);

    logic load_use, stall;

    // x0 is hardwired, so a write to it never creates a dependency.
    function automatic logic hit(input logic [RA_W-1:0] src, input logic src_used,
                                 input logic [RA_W-1:0] rd, input logic we);
        return src_used && we && (rd != '0) && (src == rd);
    endfunction

    md_seq #(.DIV_CYCLES(DIV_CYCLES)) u_md_seq (
        .clk       (clk),
        .reset     (reset),
        .ex_md     (ex_md),
        .dmem_wait (dmem_wait),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_state  (md_state)
    );

    assign load_use = ex_memread && (hit(id_rs1, id_use1, ex_rd, ex_we) ||
                                     hit(id_rs2, id_use2, ex_rd, ex_we));

`ifdef PIPE_CTRL_FWD_EN
    assign stall = load_use;

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (reset) begin
            if      (hit(ex_rs1, 1'b1, mem_rd, mem_we)) fwd_a = FWD_MEM;
            else if (hit(ex_rs1, 1'b1, wb_rd,  wb_we))  fwd_a = FWD_WB;
            if      (hit(ex_rs2, 1'b1, mem_rd, mem_we)) fwd_b = FWD_MEM;
            else if (hit(ex_rs2, 1'b1, wb_rd,  wb_we))  fwd_b = FWD_WB;
        end
    end
`else
    logic unused_ex_srcs;
    assign unused_ex_srcs = ^{ex_rs1, ex_rs2};

    // Without bypass paths the ID instruction waits until its producer retires.
    assign stall = load_use ||
                   hit(id_rs1, id_use1, ex_rd,  ex_we)  || hit(id_rs2, id_use2, ex_rd,  ex_we)  ||
                   hit(id_rs1, id_use1, mem_rd, mem_we) || hit(id_rs2, id_use2, mem_rd, mem_we) ||
                   hit(id_rs1, id_use1, wb_rd,  wb_we)  || hit(id_rs2, id_use2, wb_rd,  wb_we);
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    // Priority: reset/dmem freeze, MD busy, redirect, RAW stall, imem wait, normal.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (reset && !dmem_wait) begin
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (md_busy) begin
                ex_mem_flush = 1'b1;
            end else begin
                id_ex_en = 1'b1;
                if (ex_redirect) begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (stall) begin
                    id_ex_flush = 1'b1;
                end else if (imem_wait) begin
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                end
            end
        end
    end

endmodule
